// File: rtl/rob_ring_if.sv
// Reorder-buffer bus bundle: dispatch, CDB writeback, commit, operand lookup and occupancy status.
// The master side is dispatch/CDB/retire; the slave side is the ROB itself.
interface rob_ring_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 3,
  parameter int DEST_W = 5,
  parameter int OP_W   = 4
);
  logic              alloc_valid;
  logic              alloc_ready;
  logic [OP_W-1:0]   alloc_op;
  logic [DEST_W-1:0] alloc_dest;
  logic [IDX_W-1:0]  alloc_idx;

  logic              wb_valid;
  logic [IDX_W-1:0]  wb_idx;
  logic [DATA_W-1:0] wb_value;

  logic              commit_valid;
  logic              commit_ready;
  logic [OP_W-1:0]   commit_op;
  logic [DEST_W-1:0] commit_dest;
  logic [DATA_W-1:0] commit_value;

  logic [IDX_W-1:0]  lk_idx;
  logic              lk_ready;
  logic [DATA_W-1:0] lk_value;

  logic [IDX_W:0]    count;
  logic              empty;
  logic              full;

  modport master (
    output alloc_valid, alloc_op, alloc_dest,
    output wb_valid, wb_idx, wb_value,
    output commit_ready, lk_idx,
    input  alloc_ready, alloc_idx,
    input  commit_valid, commit_op, commit_dest, commit_value,
    input  lk_ready, lk_value, count, empty, full
  );

  modport slave (
    input  alloc_valid, alloc_op, alloc_dest,
    input  wb_valid, wb_idx, wb_value,
    input  commit_ready, lk_idx,
    output alloc_ready, alloc_idx,
    output commit_valid, commit_op, commit_dest, commit_value,
    output lk_ready, lk_value, count, empty, full
  );
endinterface

// File: rtl/rob_ring.sv
// Circular reorder buffer: allocate at tail, complete by index from the CDB, retire in order
// from head. Pointers carry an extra wrap bit so full and empty are distinguished exactly.
module rob_ring #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 3,
  parameter int DEST_W = 5,
  parameter int OP_W   = 4
) (
  input logic       clk,
  input logic       reset,
  input logic       flush,
  rob_ring_if.slave bus
);
  localparam int unsigned    DEPTH   = 2 ** IDX_W;
  localparam logic [IDX_W:0] PTR_ONE = (IDX_W + 1)'(1);

  logic [IDX_W:0]    head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0]  valid_q, valid_d, done_q, done_d;
  logic [OP_W-1:0]   op_q    [DEPTH];
  logic [OP_W-1:0]   op_d    [DEPTH];
  logic [DEST_W-1:0] dest_q  [DEPTH];
  logic [DEST_W-1:0] dest_d  [DEPTH];
  logic [DATA_W-1:0] value_q [DEPTH];
  logic [DATA_W-1:0] value_d [DEPTH];

  logic [IDX_W-1:0] head_idx, tail_idx;
  logic             full, empty, commit_valid;
  logic             alloc_fire, commit_fire, lk_fwd;

  assign head_idx     = head_q[IDX_W-1:0];
  assign tail_idx     = tail_q[IDX_W-1:0];
  assign empty        = (head_q == tail_q);
  assign full         = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
  assign commit_valid = valid_q[head_idx] && done_q[head_idx];
  assign alloc_fire   = bus.alloc_valid && !full;
  assign commit_fire  = commit_valid && bus.commit_ready;

  assign bus.alloc_ready  = !full;
  assign bus.alloc_idx    = tail_idx;
  assign bus.count        = tail_q - head_q;
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.commit_valid = commit_valid;
  assign bus.commit_op    = op_q[head_idx];
  assign bus.commit_dest  = dest_q[head_idx];
  assign bus.commit_value = value_q[head_idx];

  // A result on the CDB this cycle is visible to the lookup before it lands in storage.
  assign lk_fwd       = bus.wb_valid && (bus.wb_idx == bus.lk_idx) && valid_q[bus.lk_idx];
  assign bus.lk_ready = valid_q[bus.lk_idx] && (done_q[bus.lk_idx] || lk_fwd);
  assign bus.lk_value = lk_fwd ? bus.wb_value : value_q[bus.lk_idx];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    done_d  = done_q;
    op_d    = op_q;
    dest_d  = dest_q;
    value_d = value_q;

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      valid_d = '0;
      done_d  = '0;
    end else begin
      // Writeback is gated by the pre-cycle valid bit, so a CDB hit on the slot being
      // allocated this cycle is dropped and the allocation below wins.
      if (bus.wb_valid && valid_q[bus.wb_idx]) begin
        done_d[bus.wb_idx]  = 1'b1;
        value_d[bus.wb_idx] = bus.wb_value;
      end
      if (commit_fire) begin
        valid_d[head_idx] = 1'b0;
        head_d            = head_q + PTR_ONE;
      end
      if (alloc_fire) begin
        valid_d[tail_idx] = 1'b1;
        done_d[tail_idx]  = 1'b0;
        op_d[tail_idx]    = bus.alloc_op;
        dest_d[tail_idx]  = bus.alloc_dest;
        value_d[tail_idx] = '0;
        tail_d            = tail_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      done_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        op_q[i]    <= '0;
        dest_q[i]  <= '0;
        value_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      op_q    <= op_d;
      dest_q  <= dest_d;
      value_q <= value_d;
    end
  end
endmodule

// File: tb/tb_rob_ring.sv
// Bench for rob_ring: directed scenarios plus randomized traffic against an in-order queue model.
module tb_rob_ring;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 3;
  localparam int DEST_W = 5;
  localparam int OP_W   = 4;
  localparam int DEPTH  = 8;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  always #5 clk = ~clk;

  rob_ring_if #(.DATA_W(DATA_W), .IDX_W(IDX_W), .DEST_W(DEST_W), .OP_W(OP_W)) bus ();

  rob_ring #(.DATA_W(DATA_W), .IDX_W(IDX_W), .DEST_W(DEST_W), .OP_W(OP_W)) dut (
    .clk  (clk),
    .reset(reset),
    .flush(flush),
    .bus  (bus)
  );

  // Model: live entries oldest-first; entry k sits at ROB index (mhead + k) mod DEPTH.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DEST_W-1:0] dest;
    logic              done;
    logic [DATA_W-1:0] value;
  } ent_t;

  ent_t mq[$];
  int   mhead;
  int   vectors;
  int   miscompares;

  function automatic int mpos(input int idx);
    return (idx - mhead + DEPTH) % DEPTH;
  endfunction

  task automatic model_update();
    int   n;
    int   p;
    bit   cfire;
    bit   afire;
    ent_t e;
    if (reset || flush) begin
      mq.delete();
      mhead = 0;
      return;
    end
    n     = mq.size();
    cfire = (n > 0) && mq[0].done && bus.commit_ready;
    afire = bus.alloc_valid && (n < DEPTH);
    if (bus.wb_valid) begin
      p = mpos(int'(bus.wb_idx));
      if (p < n) begin
        e       = mq[p];
        e.done  = 1'b1;
        e.value = bus.wb_value;
        mq[p]   = e;
      end
    end
    if (cfire) begin
      void'(mq.pop_front());
      mhead = (mhead + 1) % DEPTH;
    end
    if (afire) begin
      e.op    = bus.alloc_op;
      e.dest  = bus.alloc_dest;
      e.done  = 1'b0;
      e.value = '0;
      mq.push_back(e);
    end
  endtask

  task automatic idle();
    reset            = 1'b0;
    flush            = 1'b0;
    bus.alloc_valid  = 1'b0;
    bus.alloc_op     = '0;
    bus.alloc_dest   = '0;
    bus.wb_valid     = 1'b0;
    bus.wb_idx       = '0;
    bus.wb_value     = '0;
    bus.commit_ready = 1'b0;
    bus.lk_idx       = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.alloc_ready !== 1'b1 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags ready/empty/full got %b%b%b want 110", bus.alloc_ready, bus.empty, bus.full);
    end
    vectors++;
    if (bus.count !== 4'd0 || bus.alloc_idx !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_ptrs count=%0d idx=%0d want 0 0", bus.count, bus.alloc_idx);
    end
    vectors++;
    if (bus.commit_valid !== 1'b0 || bus.lk_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid commit_valid=%b lk_ready=%b want 0 0", bus.commit_valid, bus.lk_ready);
    end
    vectors++;
    if (bus.commit_op !== '0 || bus.commit_dest !== '0 || bus.commit_value !== '0 || bus.lk_value !== '0) begin
      miscompares++;
      $display("FAIL reset_data op=%h dest=%h val=%h lk=%h want all 0",
               bus.commit_op, bus.commit_dest, bus.commit_value, bus.lk_value);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      bus.alloc_valid = 1'b1;
      bus.alloc_op    = OP_W'(i);
      bus.alloc_dest  = DEST_W'(i + 1);
      #1;
      vectors++;
      if (bus.alloc_idx !== IDX_W'(i) || bus.alloc_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL fill_idx got idx=%0d ready=%b want %0d 1", bus.alloc_idx, bus.alloc_ready, i);
      end
      tick();
    end
    vectors++;
    if (bus.full !== 1'b1 || bus.count !== 4'd8 || bus.alloc_ready !== 1'b0 || bus.empty !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_full full=%b count=%0d ready=%b empty=%b want 1 8 0 0",
               bus.full, bus.count, bus.alloc_ready, bus.empty);
    end
    tick();
    bus.alloc_valid = 1'b0;
    vectors++;
    if (bus.count !== 4'd8 || bus.alloc_idx !== 3'd0) begin
      miscompares++;
      $display("FAIL fill_blocked count=%0d idx=%0d want 8 0", bus.count, bus.alloc_idx);
    end
  endtask

  task automatic test_ooo_wb();
    bus.wb_valid = 1'b1;
    bus.wb_idx   = 3'd2;
    bus.wb_value = 32'hAA;
    tick();
    bus.wb_valid = 1'b0;
    #1;
    vectors++;
    if (bus.commit_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ooo_head_not_done commit_valid=%b want 0", bus.commit_valid);
    end
    bus.wb_valid = 1'b1;
    bus.wb_idx   = 3'd0;
    bus.wb_value = 32'h10;
    #1;
    vectors++;
    if (bus.commit_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ooo_wb_latency commit_valid=%b want 0", bus.commit_valid);
    end
    tick();
    vectors++;
    if (bus.commit_valid !== 1'b1 || bus.commit_value !== 32'h10 || bus.commit_dest !== 5'd1) begin
      miscompares++;
      $display("FAIL ooo_head0 valid=%b val=%h dest=%0d want 1 10 1",
               bus.commit_valid, bus.commit_value, bus.commit_dest);
    end
    bus.wb_idx   = 3'd1;
    bus.wb_value = 32'h11;
    tick();
    bus.wb_valid = 1'b0;
  endtask

  task automatic test_full_commit();
    bus.commit_ready = 1'b1;
    bus.alloc_valid  = 1'b1;
    bus.alloc_op     = 4'hF;
    #1;
    vectors++;
    if (bus.alloc_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL fullcommit_ready got %b want 0", bus.alloc_ready);
    end
    tick();
    bus.alloc_valid = 1'b0;
    vectors++;
    if (bus.count !== 4'd7 || bus.alloc_idx !== 3'd0 || bus.commit_value !== 32'h11 || bus.commit_dest !== 5'd2) begin
      miscompares++;
      $display("FAIL fullcommit_after count=%0d idx=%0d val=%h dest=%0d want 7 0 11 2",
               bus.count, bus.alloc_idx, bus.commit_value, bus.commit_dest);
    end
    tick();
    vectors++;
    if (bus.commit_valid !== 1'b1 || bus.commit_value !== 32'hAA || bus.commit_dest !== 5'd3) begin
      miscompares++;
      $display("FAIL inorder_idx2 valid=%b val=%h dest=%0d want 1 aa 3",
               bus.commit_valid, bus.commit_value, bus.commit_dest);
    end
    tick();
    bus.commit_ready = 1'b0;
    vectors++;
    if (bus.commit_valid !== 1'b0 || bus.count !== 4'd5) begin
      miscompares++;
      $display("FAIL inorder_stop valid=%b count=%0d want 0 5", bus.commit_valid, bus.count);
    end
  endtask

  task automatic test_lookup();
    bus.lk_idx = 3'd3;
    #1;
    vectors++;
    if (bus.lk_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL lk_pending got %b want 0", bus.lk_ready);
    end
    bus.wb_valid = 1'b1;
    bus.wb_idx   = 3'd3;
    bus.wb_value = 32'h55;
    #1;
    vectors++;
    if (bus.lk_ready !== 1'b1 || bus.lk_value !== 32'h55) begin
      miscompares++;
      $display("FAIL lk_forward ready=%b val=%h want 1 55", bus.lk_ready, bus.lk_value);
    end
    tick();
    bus.wb_valid = 1'b0;
    #1;
    vectors++;
    if (bus.lk_ready !== 1'b1 || bus.lk_value !== 32'h55) begin
      miscompares++;
      $display("FAIL lk_stored ready=%b val=%h want 1 55", bus.lk_ready, bus.lk_value);
    end
    bus.lk_idx   = 3'd1;
    bus.wb_valid = 1'b1;
    bus.wb_idx   = 3'd1;
    bus.wb_value = 32'h77;
    #1;
    vectors++;
    if (bus.lk_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL lk_invalid_entry ready=%b want 0", bus.lk_ready);
    end
    tick();
    bus.wb_valid = 1'b0;
  endtask

  task automatic test_flush();
    #1;
    vectors++;
    if (bus.count !== 4'd5 || bus.commit_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_pre count=%0d cv=%b want 5 1", bus.count, bus.commit_valid);
    end
    flush            = 1'b1;
    bus.alloc_valid  = 1'b1;
    bus.wb_valid     = 1'b1;
    bus.wb_idx       = 3'd4;
    bus.wb_value     = 32'h99;
    bus.commit_ready = 1'b1;
    tick();
    idle();
    #1;
    vectors++;
    if (bus.empty !== 1'b1 || bus.count !== 4'd0 || bus.alloc_idx !== 3'd0 || bus.commit_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_state empty=%b count=%0d idx=%0d cv=%b want 1 0 0 0",
               bus.empty, bus.count, bus.alloc_idx, bus.commit_valid);
    end
    bus.alloc_valid = 1'b1;
    tick();
    bus.alloc_valid = 1'b0;
    vectors++;
    if (bus.count !== 4'd1 || bus.alloc_idx !== 3'd1) begin
      miscompares++;
      $display("FAIL flush_realloc count=%0d idx=%0d want 1 1", bus.count, bus.alloc_idx);
    end
  endtask

  task automatic test_wrap();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int n = 0; n < 20; n++) begin
      bus.alloc_valid  = 1'b1;
      bus.alloc_dest   = DEST_W'($urandom);
      bus.wb_valid     = (n > 0);
      bus.wb_idx       = IDX_W'((n + DEPTH - 1) % DEPTH);
      bus.wb_value     = $urandom;
      bus.commit_ready = 1'b1;
      #1;
      vectors++;
      if (bus.alloc_idx !== IDX_W'(n % DEPTH) || bus.full !== 1'b0 ||
          bus.count !== 4'(mq.size()) || bus.empty !== (mq.size() == 0)) begin
        miscompares++;
        $display("FAIL wrap_step n=%0d idx=%0d full=%b count=%0d empty=%b want %0d 0 %0d %b",
                 n, bus.alloc_idx, bus.full, bus.count, bus.empty, n % DEPTH, mq.size(), mq.size() == 0);
      end
      tick();
    end
    bus.alloc_valid = 1'b0;
    bus.wb_idx      = 3'd3;
    tick();
    bus.wb_valid = 1'b0;
    for (int d = 0; d < 3; d++) tick();
    bus.commit_ready = 1'b0;
    vectors++;
    if (bus.empty !== 1'b1 || bus.count !== 4'd0 || bus.alloc_idx !== 3'd4) begin
      miscompares++;
      $display("FAIL wrap_drain empty=%b count=%0d idx=%0d want 1 0 4", bus.empty, bus.count, bus.alloc_idx);
    end
    for (int k = 0; k < DEPTH; k++) begin
      bus.alloc_valid = 1'b1;
      #1;
      vectors++;
      if (bus.alloc_idx !== IDX_W'((4 + k) % DEPTH) || bus.full !== 1'b0) begin
        miscompares++;
        $display("FAIL wrap_refill k=%0d idx=%0d full=%b want %0d 0", k, bus.alloc_idx, bus.full, (4 + k) % DEPTH);
      end
      tick();
    end
    bus.alloc_valid = 1'b0;
    vectors++;
    if (bus.full !== 1'b1 || bus.count !== 4'd8 || bus.empty !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_full full=%b count=%0d empty=%b want 1 8 0", bus.full, bus.count, bus.empty);
    end
  endtask

  task automatic test_random();
    int                n;
    int                lp;
    bit                lv;
    bit                fwd;
    bit                exp_cv;
    bit                exp_lk_ready;
    logic [DATA_W-1:0] exp_lk_value;
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 600; c++) begin
      n                = mq.size();
      flush            = ($urandom_range(0, 63) == 0);
      bus.alloc_valid  = ($urandom_range(0, 9) < 6);
      bus.alloc_op     = OP_W'($urandom);
      bus.alloc_dest   = DEST_W'($urandom);
      bus.wb_valid     = $urandom_range(0, 1);
      bus.wb_value     = $urandom;
      if (n > 0 && $urandom_range(0, 3) != 0)
        bus.wb_idx = IDX_W'((mhead + int'($urandom_range(0, n - 1))) % DEPTH);
      else
        bus.wb_idx = IDX_W'($urandom_range(0, DEPTH - 1));
      bus.commit_ready = $urandom_range(0, 1);
      bus.lk_idx       = ($urandom_range(0, 2) == 0) ? bus.wb_idx : IDX_W'($urandom_range(0, DEPTH - 1));
      #1;
      lp           = mpos(int'(bus.lk_idx));
      lv           = (lp < n);
      fwd          = bus.wb_valid && (bus.wb_idx == bus.lk_idx) && lv;
      exp_lk_ready = lv && (mq[lp].done || fwd);
      exp_lk_value = fwd ? bus.wb_value : (lv ? mq[lp].value : '0);
      exp_cv       = (n > 0) && mq[0].done;
      vectors++;
      if (bus.count !== 4'(n) || bus.empty !== (n == 0) || bus.full !== (n == DEPTH) ||
          bus.alloc_ready !== (n != DEPTH) || bus.alloc_idx !== IDX_W'((mhead + n) % DEPTH)) begin
        miscompares++;
        $display("FAIL rand_status c=%0d count=%0d empty=%b full=%b ready=%b idx=%0d want count=%0d idx=%0d",
                 c, bus.count, bus.empty, bus.full, bus.alloc_ready, bus.alloc_idx, n, (mhead + n) % DEPTH);
      end
      vectors++;
      if (bus.commit_valid !== exp_cv ||
          (exp_cv && (bus.commit_op !== mq[0].op || bus.commit_dest !== mq[0].dest ||
                      bus.commit_value !== mq[0].value))) begin
        miscompares++;
        $display("FAIL rand_commit c=%0d valid=%b op=%h dest=%h val=%h want valid=%b op=%h dest=%h val=%h",
                 c, bus.commit_valid, bus.commit_op, bus.commit_dest, bus.commit_value,
                 exp_cv, mq[0].op, mq[0].dest, mq[0].value);
      end
      vectors++;
      if (bus.lk_ready !== exp_lk_ready || (exp_lk_ready && bus.lk_value !== exp_lk_value)) begin
        miscompares++;
        $display("FAIL rand_lookup c=%0d ready=%b val=%h want %b %h",
                 c, bus.lk_ready, bus.lk_value, exp_lk_ready, exp_lk_value);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    mhead       = 0;
    test_reset();
    test_fill();
    test_ooo_wb();
    test_full_commit();
    test_lookup();
    test_flush();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
